// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS main control FSM and its datapath.
// master = control FSM side, slave = datapath side.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       branch;
  logic       branchne;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, pcwrite, branch, branchne, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, pcwrite, branch, branchne, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS core (fetch/decode/execute/mem/writeback).
// Define MC_CTRL_BNE_EN to add the bne instruction (BRANCHNE state, branchne output).
module mc_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
`ifdef MC_CTRL_BNE_EN
    , S_BRANCHNE
`endif
  } state_e;

  // fetch marks the FETCH state; irwrite/pcwrite there are qualified by mem_ready.
  typedef struct packed {
    logic       fetch;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
`ifdef MC_CTRL_BNE_EN
    logic       branchne;
`endif
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   op_known;

  // Moore decode of one state; any encoding without a row gets the FETCH controls.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BRANCHNE: begin
        c.alusrca  = 1'b1;
        c.aluop    = 2'b01;
        c.pcsrc    = 2'b01;
        c.branchne = 1'b1;
      end
`endif
      default: begin
        c.fetch   = 1'b1;
        c.alusrcb = 2'b01;
      end
    endcase
    return c;
  endfunction

  // NOTE: every variable assigned in this block gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d  = S_FETCH;
    op_known = 1'b1;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCHNE;
`endif
          default:      op_known = 1'b0;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      // Writebacks, branches, jump and unused encodings all return to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_comb ctrl_d = decode(state_d);

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order or other always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.iord       = ctrl_q.iord;
  assign bus.memwrite   = ctrl_q.memwrite;
  assign bus.regdst     = ctrl_q.regdst;
  assign bus.memtoreg   = ctrl_q.memtoreg;
  assign bus.regwrite   = ctrl_q.regwrite;
  assign bus.alusrca    = ctrl_q.alusrca;
  assign bus.alusrcb    = ctrl_q.alusrcb;
  assign bus.aluop      = ctrl_q.aluop;
  assign bus.pcsrc      = ctrl_q.pcsrc;
  assign bus.branch     = ctrl_q.branch;

  // The reset value of ctrl_q is the FETCH row, so the ready-qualified strobes must
  // also be masked by reset itself to stay quiet while reset is held.
  assign bus.irwrite    = ctrl_q.fetch & bus.mem_ready & ~reset;
  assign bus.pcwrite    = (ctrl_q.pcwrite | (ctrl_q.fetch & bus.mem_ready)) & ~reset;
  assign bus.illegal_op = (state_q == S_DECODE) & ~op_known & ~reset;

`ifdef MC_CTRL_BNE_EN
  assign bus.branchne   = ctrl_q.branchne;
`else
  assign bus.branchne   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed cases then random instruction streams,
// each checked cycle by cycle against a per-instruction expected phase trace.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum {
    P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXECUTE, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_BRANCHNE
  } phase_e;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       illegal_op;
  } ctl_t;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Control table of the specification, one row per phase.
  function automatic ctl_t expect_ctl(input phase_e p, input bit rdy, input bit bad_op);
    ctl_t c;
    c = '0;
    case (p)
      P_RESET:    c.alusrcb = 2'b01;
      P_FETCH:    begin c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
      P_DECODE:   begin c.alusrcb = 2'b11; c.illegal_op = bad_op; end
      P_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      P_MEMRD:    c.iord = 1'b1;
      P_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      P_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      P_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      P_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      P_BRANCH:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      P_ADDIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      P_ADDIWB:   c.regwrite = 1'b1;
      P_JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      P_BRANCHNE: begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branchne = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.iord       = bus.iord;
    c.memwrite   = bus.memwrite;
    c.irwrite    = bus.irwrite;
    c.regdst     = bus.regdst;
    c.memtoreg   = bus.memtoreg;
    c.regwrite   = bus.regwrite;
    c.alusrca    = bus.alusrca;
    c.alusrcb    = bus.alusrcb;
    c.aluop      = bus.aluop;
    c.pcsrc      = bus.pcsrc;
    c.pcwrite    = bus.pcwrite;
    c.branch     = bus.branch;
    c.branchne   = bus.branchne;
    c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    case (o)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
`ifdef MC_CTRL_BNE_EN
      OP_BNE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Entered and left at posedge+1 of a cycle. Builds the phase trace for one instruction
  // (waits expand into repeated phases with mem_ready low), then plays it.
  // abort=1 stops a load inside its memory wait and asserts reset instead.
  task automatic run_instr(input logic [5:0] opc, input int wf, input int wm, input bit abort);
    phase_e ph[$];
    bit     rd[$];
    bit     bad_op;
    int     wr_exp;
    int     wr_seen;
    ctl_t   got;
    bad_op  = 1'b0;
    wr_exp  = 0;
    wr_seen = 0;
    for (int i = 0; i < wf; i++) begin ph.push_back(P_FETCH); rd.push_back(1'b0); end
    ph.push_back(P_FETCH);  rd.push_back(1'b1);
    ph.push_back(P_DECODE); rd.push_back(1'($urandom_range(0, 1)));
    case (opc)
      OP_LW: begin
        ph.push_back(P_MEMADR); rd.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < (abort ? 1 : wm); i++) begin ph.push_back(P_MEMRD); rd.push_back(1'b0); end
        if (!abort) begin
          ph.push_back(P_MEMRD); rd.push_back(1'b1);
          ph.push_back(P_MEMWB); rd.push_back(1'($urandom_range(0, 1)));
          wr_exp = 1;
        end
      end
      OP_SW: begin
        ph.push_back(P_MEMADR); rd.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin ph.push_back(P_MEMWR); rd.push_back(1'b0); end
        ph.push_back(P_MEMWR); rd.push_back(1'b1);
      end
      OP_RTYPE: begin
        ph.push_back(P_EXECUTE); rd.push_back(1'($urandom_range(0, 1)));
        ph.push_back(P_ALUWB);   rd.push_back(1'($urandom_range(0, 1)));
        wr_exp = 1;
      end
      OP_BEQ:  begin ph.push_back(P_BRANCH); rd.push_back(1'($urandom_range(0, 1))); end
      OP_ADDI: begin
        ph.push_back(P_ADDIEX); rd.push_back(1'($urandom_range(0, 1)));
        ph.push_back(P_ADDIWB); rd.push_back(1'($urandom_range(0, 1)));
        wr_exp = 1;
      end
      OP_J:    begin ph.push_back(P_JUMP); rd.push_back(1'($urandom_range(0, 1))); end
`ifdef MC_CTRL_BNE_EN
      OP_BNE:  begin ph.push_back(P_BRANCHNE); rd.push_back(1'($urandom_range(0, 1))); end
`endif
      default: bad_op = 1'b1;
    endcase

    for (int i = 0; i < ph.size(); i++) begin
      bus.op        = opc;
      bus.mem_ready = rd[i];
      @(negedge clk);
      got = sample();
      check($sformatf("%s op=%b", ph[i].name(), opc), 32'(got),
            32'(expect_ctl(ph[i], rd[i], bad_op && ph[i] == P_DECODE)));
      check("one_write", 32'($countones({got.regwrite, got.memwrite, got.irwrite}) <= 1), 32'd1);
      wr_seen += int'(got.regwrite);
      @(posedge clk);
      #1;
    end

    if (abort) begin
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      got = sample();
      check("abort_reset", 32'(got), 32'(expect_ctl(P_RESET, 1'b1, 1'b0)));
      wr_seen += int'(got.regwrite);
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
    check($sformatf("regwrite_count op=%b", opc), 32'(wr_seen), 32'(wr_exp));
  endtask

  logic [5:0] rop;
  ctl_t       rst_got;

  initial begin
    reset         = 1'b1;
    bus.op        = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_got = sample();
      check("reset", 32'(rst_got), 32'(expect_ctl(P_RESET, 1'b1, 1'b0)));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases.
    run_instr(OP_LW,    0, 0, 1'b0);
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_BEQ,   0, 0, 1'b0);
    run_instr(OP_SW,    0, 3, 1'b0);
    run_instr(OP_ADDI,  2, 0, 1'b0);
    run_instr(OP_J,     0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_LW,    0, 2, 1'b1);
    run_instr(OP_RTYPE, 1, 0, 1'b0);
    run_instr(OP_BNE,   0, 0, 1'b0);
    run_instr(OP_LW,    1, 3, 1'b0);

    // Random instruction stream with random wait states.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_RTYPE;
        3: rop = OP_BEQ;
        4: rop = OP_ADDI;
        5: rop = OP_J;
        6: rop = OP_BNE;
        default: begin
          rop = 6'($urandom);
          if (is_legal(rop)) rop = 6'b111111;
        end
      endcase
      run_instr(rop, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0) && rop == OP_LW);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
